keypad_lock_ctrl: RTL
=====================

Name: keypad_lock_ctrl

Overview:
Sequencing controller for the keypad password lock. It consumes the 16 debounced key levels from the key filter and turns them into single press events. It runs the entry / check / fail / lockout / unlocked / set-password state machine, keeps the failed-try count, and drives the digit buffer and status flags for the display block.

Parameters:
PW_LEN, 4, digits per password (1..8)
MAX_TRIES, 5, consecutive failures that trigger lockout (1..15)
FAIL_TICKS, 25_000_000, clk cycles fail_flash is held after a wrong entry
LOCK_TICKS, 250_000_000, clk cycles of lockout
DEFAULT_PW, 16'h1234, reset password, BCD nibbles, MS nibble = first digit (width 4*PW_LEN)

Ports:
clk  in  1  system clock
rstn  in  1  reset, asynchronous, active-low
key_deb  in  16  debounced key levels, 1 = pressed; bits 0-9 digits, 10 CLR, 11 ENT, 12 SET, 13-15 ignored
digits  out  4*PW_LEN  entered BCD digits, newest in LS nibble
digit_cnt  out  4  number of digits entered (0..PW_LEN)
unlocked  out  1  high in UNLOCKED and SET
set_mode  out  1  high in SET
fail_flash  out  1  high in FAIL
locked_out  out  1  high in LOCKOUT
tries_out  out  4  consecutive failed attempts

Behaviour:
- Reset (async): state ENTRY; digits=0, digit_cnt=0, tries_out=0, all flags 0; pw register = DEFAULT_PW.
- Press detect: key_prev <= key_deb each cycle.
  - press = (key_prev==0) && (key_deb!=0).
  - code = index of lowest set bit of key_deb.
  - Held keys never retrigger. A second key added while one is held is ignored until all keys are released.
- Action latency: the state/register update is visible on the clk edge after the cycle in which press is high.
- ENTRY:
  - Digit with digit_cnt<PW_LEN: digits <= {digits<<4 | code}, digit_cnt+1.
  - Digit with digit_cnt==PW_LEN: ignored.
  - CLR: digits=0, digit_cnt=0.
  - ENT with digit_cnt==PW_LEN: -> CHECK. ENT otherwise: ignored.
  - SET and keys 13-15: ignored.
- CHECK (exactly 1 cycle, keys ignored): digits, digit_cnt cleared on exit.
  - digits==pw: -> UNLOCKED, tries_out=0.
  - Mismatch and tries_out+1==MAX_TRIES: -> LOCKOUT, tries_out=MAX_TRIES.
  - Mismatch otherwise: -> FAIL, tries_out+1.
- FAIL:
  - Timer loaded FAIL_TICKS-1 on entry, counts down; at 0 -> ENTRY.
  - All presses discarded, including presses landing on the exit cycle.
- LOCKOUT:
  - Same timer mechanism with LOCK_TICKS; presses discarded.
  - Exit -> ENTRY, tries_out=0.
- UNLOCKED:
  - CLR -> ENTRY (relock), digits cleared.
  - SET -> SET state, digits cleared.
  - Other keys ignored.
- SET:
  - Digit entry rules identical to ENTRY.
  - ENT with digit_cnt==PW_LEN: pw <= digits, -> UNLOCKED, digits cleared.
  - CLR: abort, pw unchanged, -> UNLOCKED, digits cleared.
- Timer: single down-counter, 32 bits, shared by FAIL and LOCKOUT.
- Flags: decoded from state, registered (no combinational path from key_deb).
- Reset mid-operation: any state returns to reset values; an updated pw is lost and reverts to DEFAULT_PW.

Test Plan:
Bench parameters: PW_LEN=4, MAX_TRIES=3, FAIL_TICKS=8, LOCK_TICKS=20.
1. Press 1,2,3,4, ENT (release between each) -> digits 16'h1234 before ENT; unlocked=1 two cycles after ENT press; tries_out=0, digits=0.
2. Press 1,2,3,5, ENT -> fail_flash=1 for exactly 8 cycles, tries_out=1; keys pressed during FAIL have no effect; back in ENTRY with digit_cnt=0.
3. Three wrong entries -> third goes to LOCKOUT; locked_out=1 for 20 cycles, tries_out=3 during lockout, then 0. Correct code afterwards unlocks.
4. Key 7 held 50 cycles -> digit_cnt increments once. Keys 3+5 pressed same cycle -> code 3 accepted. Fifth digit after four -> ignored. ENT with 3 digits -> ignored. CLR -> digit_cnt=0.
5. Unlock, SET, 9,8,7,6, ENT -> set_mode drops, unlocked=1. CLR relocks. 1234+ENT fails; 9876+ENT unlocks. SET then CLR -> pw unchanged.
6. Assert rstn low during LOCKOUT and after password change -> all outputs 0 immediately. 1234 unlocks again.

Source files
------------

// File: rtl/keypad_lock_ctrl.sv
// Keypad lock sequencer: turns debounced key levels into press events and runs the
// entry / check / fail / lockout / unlocked / set-password state machine.
module keypad_lock_ctrl #(
    parameter int unsigned           PW_LEN     = 4,
    parameter int unsigned           MAX_TRIES  = 5,
    parameter int unsigned           FAIL_TICKS = 25_000_000,
    parameter int unsigned           LOCK_TICKS = 250_000_000,
    parameter logic [4*PW_LEN-1:0]   DEFAULT_PW = (4*PW_LEN)'(16'h1234)
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic [15:0]           key_deb,
    output logic [4*PW_LEN-1:0]   digits,
    output logic [3:0]            digit_cnt,
    output logic                  unlocked,
    output logic                  set_mode,
    output logic                  fail_flash,
    output logic                  locked_out,
    output logic [3:0]            tries_out
);

    localparam int DW = 4 * PW_LEN;

    typedef enum logic [2:0] {
        ST_ENTRY,
        ST_CHECK,
        ST_FAIL,
        ST_LOCKOUT,
        ST_UNLOCKED,
        ST_SET
    } state_t;

    state_t          state_q, state_d;
    logic [15:0]     key_prev_q;
    logic [DW-1:0]   digits_q, digits_d;
    logic [3:0]      cnt_q, cnt_d;
    logic [3:0]      tries_q, tries_d;
    logic [DW-1:0]   pw_q, pw_d;
    logic [31:0]     timer_q, timer_d;
    logic            unlocked_q, unlocked_d;
    logic            set_mode_q, set_mode_d;
    logic            fail_q, fail_d;
    logic            lock_q, lock_d;

    logic            press;
    logic [3:0]      code;
    logic            is_digit, is_clr, is_ent, is_set;

    // A press is only recognised when every key was released the cycle before.
    always_comb begin
        press = (key_prev_q == 16'h0000) && (key_deb != 16'h0000);
        code  = 4'd0;
        for (int i = 15; i >= 0; i--) begin
            if (key_deb[i]) begin
                code = 4'(i);
            end
        end
        is_digit = press && (code < 4'd10);
        is_clr   = press && (code == 4'd10);
        is_ent   = press && (code == 4'd11);
        is_set   = press && (code == 4'd12);
    end

    always_comb begin
        state_d  = state_q;
        digits_d = digits_q;
        cnt_d    = cnt_q;
        tries_d  = tries_q;
        pw_d     = pw_q;
        timer_d  = timer_q;

        case (state_q)
            ST_ENTRY, ST_SET: begin
                if (is_digit) begin
                    if (cnt_q < 4'(PW_LEN)) begin
                        digits_d = (digits_q << 4) | DW'(code);
                        cnt_d    = cnt_q + 4'd1;
                    end
                end else if (is_clr) begin
                    digits_d = '0;
                    cnt_d    = 4'd0;
                    if (state_q == ST_SET) begin
                        state_d = ST_UNLOCKED;
                    end
                end else if (is_ent && (cnt_q == 4'(PW_LEN))) begin
                    if (state_q == ST_ENTRY) begin
                        state_d = ST_CHECK;
                    end else begin
                        pw_d     = digits_q;
                        digits_d = '0;
                        cnt_d    = 4'd0;
                        state_d  = ST_UNLOCKED;
                    end
                end
            end

            ST_CHECK: begin
                digits_d = '0;
                cnt_d    = 4'd0;
                if (digits_q == pw_q) begin
                    state_d = ST_UNLOCKED;
                    tries_d = 4'd0;
                end else if ((tries_q + 4'd1) == 4'(MAX_TRIES)) begin
                    state_d = ST_LOCKOUT;
                    tries_d = 4'(MAX_TRIES);
                    timer_d = 32'(LOCK_TICKS - 1);
                end else begin
                    state_d = ST_FAIL;
                    tries_d = tries_q + 4'd1;
                    timer_d = 32'(FAIL_TICKS - 1);
                end
            end

            // Both penalty states share the timer; presses are simply never looked at here.
            ST_FAIL, ST_LOCKOUT: begin
                if (timer_q == 32'd0) begin
                    state_d = ST_ENTRY;
                    if (state_q == ST_LOCKOUT) begin
                        tries_d = 4'd0;
                    end
                end else begin
                    timer_d = timer_q - 32'd1;
                end
            end

            ST_UNLOCKED: begin
                if (is_clr) begin
                    state_d  = ST_ENTRY;
                    digits_d = '0;
                    cnt_d    = 4'd0;
                end else if (is_set) begin
                    state_d  = ST_SET;
                    digits_d = '0;
                    cnt_d    = 4'd0;
                end
            end

            default: begin
                state_d  = ST_ENTRY;
                digits_d = '0;
                cnt_d    = 4'd0;
            end
        endcase

        unlocked_d = (state_d == ST_UNLOCKED) || (state_d == ST_SET);
        set_mode_d = (state_d == ST_SET);
        fail_d     = (state_d == ST_FAIL);
        lock_d     = (state_d == ST_LOCKOUT);
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q    <= ST_ENTRY;
            key_prev_q <= 16'h0000;
            digits_q   <= '0;
            cnt_q      <= 4'd0;
            tries_q    <= 4'd0;
            pw_q       <= DEFAULT_PW;
            timer_q    <= 32'd0;
            unlocked_q <= 1'b0;
            set_mode_q <= 1'b0;
            fail_q     <= 1'b0;
            lock_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            key_prev_q <= key_deb;
            digits_q   <= digits_d;
            cnt_q      <= cnt_d;
            tries_q    <= tries_d;
            pw_q       <= pw_d;
            timer_q    <= timer_d;
            unlocked_q <= unlocked_d;
            set_mode_q <= set_mode_d;
            fail_q     <= fail_d;
            lock_q     <= lock_d;
        end
    end

    assign digits     = digits_q;
    assign digit_cnt  = cnt_q;
    assign unlocked   = unlocked_q;
    assign set_mode   = set_mode_q;
    assign fail_flash = fail_q;
    assign locked_out = lock_q;
    assign tries_out  = tries_q;

endmodule
